// File: rtl/prog_loader_if.sv
// Byte-stream input, memory write port and boot status of the program loader.
interface prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              reload;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;
  logic [15:0]       words_loaded;

  modport master (
    output in_valid, in_data, reload,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err, words_loaded
  );

  modport slave (
    input  in_valid, in_data, reload,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err, words_loaded
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: parses a framed byte stream into 16-bit words, writes them to
// program memory and releases the processor once the frame checksum is valid.
module prog_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                TIMEOUT   = 1024
) (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_CNT_LO, S_CNT_HI, S_DAT_LO, S_DAT_HI, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam int                TMR_W     = $clog2(TIMEOUT + 1);
  localparam logic [16:0]       MAX_WORDS = 17'(1) << ADDR_W;
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_cnt,   w_cnt_nxt;
  logic [7:0]        r_lo,    w_lo_nxt;
  logic [7:0]        r_sum,   w_sum_nxt;
  logic [TMR_W-1:0]  r_timer, w_timer_nxt;
  logic              r_we,    w_we_nxt;
  logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
  logic [15:0]       r_wdata, w_wdata_nxt;
  logic [15:0]       r_words, w_words_nxt;

  logic              w_loading;
  logic              w_accept;
  logic [7:0]        w_sum_byte;
  logic [15:0]       w_n;

  assign w_loading  = (r_state != S_DONE) && (r_state != S_ERR);
  // reload takes priority, so a byte offered in the same cycle is never consumed
  assign w_accept   = bus.in_valid & w_loading & ~bus.reload;
  assign w_sum_byte = r_sum + bus.in_data;
  assign w_n        = {bus.in_data, r_cnt[7:0]};

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lo_nxt    = r_lo;
    w_sum_nxt   = r_sum;
    w_timer_nxt = r_timer;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_words_nxt = r_words;

    if (bus.reload) begin
      w_state_nxt = S_CNT_LO;
      w_sum_nxt   = '0;
      w_words_nxt = '0;
      w_timer_nxt = '0;
    end else if (w_accept) begin
      w_sum_nxt   = w_sum_byte;
      w_timer_nxt = '0;
      case (r_state)
        S_CNT_LO: begin
          w_cnt_nxt[7:0] = bus.in_data;
          w_state_nxt    = S_CNT_HI;
        end
        S_CNT_HI: begin
          w_cnt_nxt[15:8] = bus.in_data;
          if (w_n == 16'd0)                w_state_nxt = S_CHK;
          else if ({1'b0, w_n} > MAX_WORDS) w_state_nxt = S_ERR;
          else                             w_state_nxt = S_DAT_LO;
        end
        S_DAT_LO: begin
          w_lo_nxt    = bus.in_data;
          w_state_nxt = S_DAT_HI;
        end
        S_DAT_HI: begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = BASE_ADDR + r_words[ADDR_W-1:0];
          w_wdata_nxt = {bus.in_data, r_lo};
          w_words_nxt = r_words + 16'd1;
          w_state_nxt = (r_words == r_cnt - 16'd1) ? S_CHK : S_DAT_LO;
        end
        S_CHK:   w_state_nxt = (w_sum_byte == 8'd0) ? S_DONE : S_ERR;
        default: ;
      endcase
    end else if (w_loading && r_state != S_CNT_LO) begin
      // Abort on the edge where the idle count would reach TIMEOUT.
      if (r_timer == TMR_LAST) begin
        w_state_nxt = S_ERR;
        w_timer_nxt = '0;
      end else begin
        w_timer_nxt = r_timer + TMR_W'(1);
      end
    end else begin
      w_timer_nxt = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the async
  // reset is in the sensitivity list so it acts without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CNT_LO;
      r_cnt   <= '0;
      r_lo    <= '0;
      r_sum   <= '0;
      r_timer <= '0;
      r_we    <= 1'b0;
      r_addr  <= BASE_ADDR;
      r_wdata <= '0;
      r_words <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lo    <= w_lo_nxt;
      r_sum   <= w_sum_nxt;
      r_timer <= w_timer_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_words <= w_words_nxt;
    end
  end

  assign bus.in_ready     = w_loading;
  assign bus.mem_we       = r_we;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_wdata    = r_wdata;
  assign bus.cpu_rst      = (r_state != S_DONE);
  assign bus.done         = (r_state == S_DONE);
  assign bus.err          = (r_state == S_ERR);
  assign bus.words_loaded = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus random frames scored
// against a frame-level model of the boot protocol.
`timescale 1ns/1ps
module tb_prog_loader;
  localparam int                ADDR_W  = 8;
  localparam int                TIMEOUT = 16;
  localparam logic [ADDR_W-1:0] BASE    = '0;

  typedef logic [7:0]        bytes_t[$];
  typedef logic [ADDR_W+15:0] wr_t;
  typedef wr_t               wrs_t[$];

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  wr_t         wr_seen[$];
  logic [15:0] wl_seen[$];

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Write monitor: records every memory write and the word count shown with it.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_seen.push_back({bus.mem_addr, bus.mem_wdata});
      wl_seen.push_back(bus.words_loaded);
    end
  end

  // Frame-level model: decode count, list the writes, judge the checksum.
  function automatic void model(input bytes_t b, output wrs_t w,
                                output logic e_done, output logic e_err);
    int n;
    int sum;
    w = {}; e_done = 1'b0; e_err = 1'b0; sum = 0;
    n = int'(b[0]) + 256 * int'(b[1]);
    if (n > (1 << ADDR_W)) begin
      e_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++)
      w.push_back({ADDR_W'(int'(BASE) + i), b[3 + 2*i], b[2 + 2*i]});
    foreach (b[i]) sum += int'(b[i]);
    if (sum % 256 == 0) e_done = 1'b1;
    else                e_err  = 1'b1;
  endfunction

  function automatic void make_frame(input int n, input bit good, output bytes_t b);
    int sum;
    b = {};
    sum = 0;
    b.push_back(8'(n));
    b.push_back(8'(n >> 8));
    for (int i = 0; i < 2*n; i++) b.push_back(8'($urandom));
    foreach (b[i]) sum += int'(b[i]);
    b.push_back(8'(256 - sum % 256) + (good ? 8'd0 : 8'd1));
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.reload   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reload();
    bus.reload = 1'b1;
    @(negedge clk);
    bus.reload = 1'b0;
  endtask

  // Returns on the falling edge right after the last byte is accepted.
  task automatic send_frame(input bytes_t b, input int max_gap);
    foreach (b[i]) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drive_and_score(input bytes_t b, input int max_gap, input string name);
    wrs_t exp;
    logic e_done, e_err;
    model(b, exp, e_done, e_err);
    wr_seen.delete();
    wl_seen.delete();
    send_frame(b, max_gap);
    n_checks++;
    if (bus.done !== e_done) begin
      n_errors++; $display("FAIL %s done: got %b want %b", name, bus.done, e_done);
    end
    n_checks++;
    if (bus.err !== e_err) begin
      n_errors++; $display("FAIL %s err: got %b want %b", name, bus.err, e_err);
    end
    n_checks++;
    if (bus.cpu_rst !== ~e_done) begin
      n_errors++; $display("FAIL %s cpu_rst: got %b want %b", name, bus.cpu_rst, ~e_done);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_errors++; $display("FAIL %s in_ready: got %b want 0", name, bus.in_ready);
    end
    n_checks++;
    if (bus.words_loaded !== 16'(exp.size())) begin
      n_errors++; $display("FAIL %s words_loaded: got %0d want %0d", name, bus.words_loaded, exp.size());
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_seen.size() != exp.size()) begin
      n_errors++; $display("FAIL %s write count: got %0d want %0d", name, wr_seen.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < wr_seen.size(); i++) begin
      n_checks++;
      if (wr_seen[i] !== exp[i]) begin
        n_errors++; $display("FAIL %s write %0d addr/data: got %h want %h", name, i, wr_seen[i], exp[i]);
      end
      n_checks++;
      if (wl_seen[i] !== 16'(i + 1)) begin
        n_errors++; $display("FAIL %s words_loaded at write %0d: got %0d want %0d", name, i, wl_seen[i], i + 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.reload   = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.cpu_rst, bus.done, bus.err, bus.mem_we, bus.in_ready} !== 5'b10001) begin
      n_errors++; $display("FAIL reset flags: got %b want 10001",
        {bus.cpu_rst, bus.done, bus.err, bus.mem_we, bus.in_ready});
    end
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.words_loaded} !== {BASE, 16'h0, 16'h0}) begin
      n_errors++; $display("FAIL reset values: addr=%h wdata=%h words=%h want %h/0/0",
        bus.mem_addr, bus.mem_wdata, bus.words_loaded, BASE);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    bytes_t b;
    b = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40};
    do_reset();
    drive_and_score(b, 0, "nominal");
    n_checks++;
    if (wr_seen.size() != 2 || wr_seen[0] !== {8'h00, 16'h1234} || wr_seen[1] !== {8'h01, 16'hABCD}) begin
      n_errors++; $display("FAIL nominal literal writes: got %0d writes, first %h", wr_seen.size(),
        (wr_seen.size() > 0) ? wr_seen[0] : '0);
    end
  endtask

  task automatic test_gaps();
    bytes_t b;
    b = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      drive_and_score(b, 5, "gaps");
    end
  endtask

  task automatic test_bad_checksum();
    bytes_t b;
    b = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h41};
    do_reset();
    drive_and_score(b, 0, "bad_checksum");
    pulse_reload();
    n_checks++;
    if ({bus.cpu_rst, bus.done, bus.err, bus.in_ready} !== 4'b1001 || bus.words_loaded !== 16'd0) begin
      n_errors++; $display("FAIL reload state: flags=%b words=%0d want 1001/0",
        {bus.cpu_rst, bus.done, bus.err, bus.in_ready}, bus.words_loaded);
    end
    b = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40};
    drive_and_score(b, 0, "after_reload");
  endtask

  task automatic test_empty_and_overlength();
    bytes_t b;
    b = '{8'h00, 8'h00, 8'h00};
    do_reset();
    drive_and_score(b, 0, "empty");
    b = '{8'h01, 8'h01};
    do_reset();
    drive_and_score(b, 0, "overlength");
  endtask

  task automatic test_full_image();
    bytes_t b;
    make_frame(1 << ADDR_W, 1'b1, b);
    do_reset();
    drive_and_score(b, 0, "full_image");
  endtask

  task automatic test_timeout();
    bytes_t b;
    int cycles;
    b = '{8'h02, 8'h00, 8'h34};
    do_reset();
    send_frame(b, 0);
    cycles = 0;
    while (bus.err !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    n_checks++;
    if (cycles != TIMEOUT) begin
      n_errors++; $display("FAIL timeout latency: got %0d cycles want %0d", cycles, TIMEOUT);
    end
    n_checks++;
    if (bus.cpu_rst !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_errors++; $display("FAIL timeout outputs: cpu_rst=%b in_ready=%b want 1/0", bus.cpu_rst, bus.in_ready);
    end
  endtask

  task automatic test_reload_drop();
    bytes_t b;
    b = '{8'h02, 8'h00, 8'h34};
    do_reset();
    send_frame(b, 0);
    wr_seen.delete();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h12;
    bus.reload   = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.reload   = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr_seen.size() != 0 || bus.words_loaded !== 16'd0 || bus.in_ready !== 1'b1) begin
      n_errors++; $display("FAIL reload_drop: writes=%0d words=%0d in_ready=%b want 0/0/1",
        wr_seen.size(), bus.words_loaded, bus.in_ready);
    end
    b = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40};
    drive_and_score(b, 0, "after_reload_drop");
  endtask

  task automatic test_reset_midframe();
    bytes_t b;
    b = '{8'h02, 8'h00, 8'h34, 8'h12};
    do_reset();
    send_frame(b, 0);
    n_checks++;
    if (bus.mem_we !== 1'b1 || bus.words_loaded !== 16'd1) begin
      n_errors++; $display("FAIL midframe pre-reset: mem_we=%b words=%0d want 1/1", bus.mem_we, bus.words_loaded);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.cpu_rst, bus.done, bus.err, bus.mem_we, bus.in_ready} !== 5'b10001 ||
        {bus.mem_addr, bus.mem_wdata, bus.words_loaded} !== {BASE, 16'h0, 16'h0}) begin
      n_errors++; $display("FAIL midframe reset: flags=%b addr=%h wdata=%h words=%h want 10001/%h/0/0",
        {bus.cpu_rst, bus.done, bus.err, bus.mem_we, bus.in_ready},
        bus.mem_addr, bus.mem_wdata, bus.words_loaded, BASE);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    bytes_t b;
    for (int k = 0; k < 10; k++) begin
      make_frame($urandom_range(12, 0), ($urandom_range(3, 0) != 0), b);
      if (k % 2 == 0) do_reset();
      else            pulse_reload();
      drive_and_score(b, $urandom_range(3, 0), "random");
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_gaps();
    test_bad_checksum();
    test_empty_and_overlength();
    test_full_image();
    test_timeout();
    test_reload_drop();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream boot stage for the 16-bit single-cycle processor.
- Receives a framed program image as a byte stream (valid/ready) and assembles 16-bit words.
- Writes each word into instruction/data memory through a dedicated write port.
- Holds the processor in reset until a complete frame with a valid checksum has been written, then releases it.

Parameters:
- ADDR_W, 8, memory word-address width; the image can hold at most 2**ADDR_W words.
- BASE_ADDR, 0, address of the first word written; the width of this value is ADDR_W.
- TIMEOUT, 1024, idle cycles allowed between bytes inside a frame before the frame is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- in_valid  in  1  byte available
- in_data  in  8  byte value
- in_ready  out  1  loader can accept a byte; a byte transfers when in_valid and in_ready are both high on a clk edge
- reload  in  1  one-cycle pulse that restarts loading
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory write word address
- mem_wdata  out  16  memory write data
- cpu_rst  out  1  processor reset, active-high
- done  out  1  image loaded and checksum valid
- err  out  1  frame rejected
- words_loaded  out  16  number of words written in the current frame

Behaviour:
- Frame byte order:
  - CNT_LO, CNT_HI: word count N, little-endian.
  - N word pairs, each sent as LO byte then HI byte.
  - CHK byte.
  - The frame is valid when the 8-bit sum of all bytes, including CHK, is 0 mod 256.
- States: S_CNT_LO, S_CNT_HI, S_DAT_LO, S_DAT_HI, S_CHK, S_DONE, S_ERR.
- in_ready = 1 in S_CNT_LO through S_CHK; 0 in S_DONE and S_ERR. It is decoded from state only and never depends on in_valid.
- Reset values:
  - state = S_CNT_LO, cpu_rst = 1.
  - done = 0, err = 0.
  - mem_we = 0, mem_addr = BASE_ADDR, mem_wdata = 0.
  - words_loaded = 0.
  - Checksum accumulator = 0, timeout counter = 0.
- Transitions (each on an accepted byte; the byte is added to the running sum):
  - S_CNT_LO -> S_CNT_HI.
  - S_CNT_HI:
    - N == 0 -> S_CHK.
    - N > 2**ADDR_W -> S_ERR. The count bytes are accepted but no writes are issued.
    - Otherwise -> S_DAT_LO.
  - S_DAT_LO: latch the low byte -> S_DAT_HI.
  - S_DAT_HI: issue a write, then:
    - -> S_CHK if this was word N;
    - otherwise -> S_DAT_LO.
  - S_CHK:
    - sum including CHK == 0 -> S_DONE;
    - otherwise -> S_ERR.
- Write timing:
  - The cycle after the HI byte is accepted, the registered outputs hold:
    - mem_we = 1 for exactly one cycle;
    - mem_addr = BASE_ADDR + word index, computed mod 2**ADDR_W;
    - mem_wdata = {HI, LO}.
  - words_loaded increments in the same cycle.
  - Back-to-back bytes are accepted at one per cycle with no stalls.
- Outputs per state:
  - S_DONE: cpu_rst = 0, done = 1. The state persists.
  - S_ERR: cpu_rst = 1, err = 1. The state persists. Words already written stay in memory; the processor is never released.
  - All other states: cpu_rst = 1, done = 0, err = 0.
- Timeout:
  - The counter clears on every accepted byte and whenever the state is S_CNT_LO.
  - It increments each cycle in S_CNT_HI through S_CHK while no byte is accepted.
  - When it reaches TIMEOUT, go to S_ERR.
  - Waiting in S_CNT_LO never times out.
- reload:
  - Any state -> S_CNT_LO.
  - Clears the sum, words_loaded, done and err.
  - Reasserts cpu_rst the next cycle.
  - If a byte handshake happens in the same cycle as reload, the byte is dropped and reload wins.
- Reset at any point, mid-frame or in S_DONE, returns every register to its reset value immediately (asynchronous).
- in_valid gaps inside the frame do not affect content. Only the timeout applies.

Test Plan:
- Nominal frame, bytes 02 00 34 12 CD AB 40, one per cycle:
  - mem_we pulses write 0x1234 at address 0, then 0xABCD at address 1;
  - words_loaded = 2;
  - done = 1 and cpu_rst = 0 one cycle after the 0x40 byte is accepted.
- Same frame with random 0-5 cycle in_valid gaps (TIMEOUT = 16):
  - identical writes, same end state.
- Bad checksum, frame ending in 0x41 instead of 0x40:
  - both writes occur;
  - then err = 1 and cpu_rst stays 1;
  - in_ready = 0.
  - A following reload pulse, then the nominal frame -> done = 1, err = 0.
- Empty frame, bytes 00 00 00:
  - no mem_we;
  - done = 1, words_loaded = 0.
- Overlength frame, ADDR_W = 8, bytes 01 01:
  - err = 1 after the second byte;
  - no writes.
- Timeout, TIMEOUT = 16, bytes 02 00 34 then in_valid held low:
  - err = 1 exactly 16 cycles after the 0x34 byte is accepted.
  - Separately: rst asserted mid-frame -> all outputs return to their reset values.
